i8008_addr_stack: RTL and testbench
===================================

Name: i8008_addr_stack

Overview:
- Parametrised program-counter/return-address stack for the i8008 core family, generalising the fixed 8-level, 14-bit 8008 stack.
- Depth, address width and overflow policy are configurable.
- The top-of-stack entry is the live PC. The core issues one op per cycle: increment, jump, call, return, or RST vector.
- Adds occupancy tracking, overflow/underflow pulses, and a sticky fault flag for the non-wrapping mode.

Parameters:
ADDR_WIDTH, 14, PC/return address width in bits; must be >= 6.
DEPTH, 8, total entries including the live PC; power of two, >= 2; max nesting = DEPTH-1.
WRAP_MODE, 1, 1 = circular 8008 behaviour (overwrite oldest / stale pop); 0 = saturating, illegal ops ignored and fault set.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
op  input  3  000 NOP, 001 INC, 010 JUMP, 011 CALL, 100 RET, 101 RSTV, 110/111 treated as NOP
addr_in  input  ADDR_WIDTH  target address for JUMP/CALL
vec_in  input  3  RST vector number for RSTV
clr_fault  input  1  synchronous clear of fault
pc  output  ADDR_WIDTH  current top-of-stack entry (live PC)
level  output  $clog2(DEPTH)  number of saved return addresses, 0..DEPTH-1
overflow  output  1  one-cycle pulse: CALL/RSTV issued with level == DEPTH-1
underflow  output  1  one-cycle pulse: RET issued with level == 0
fault  output  1  sticky error flag, saturating mode only

Behaviour:
- Reset (async, rst high):
  - all entries, stack pointer sp and level = 0, so pc = 0 immediately;
  - overflow, underflow, fault = 0;
  - takes effect mid-operation with no wait for clk; a pending op is discarded.
- Storage: DEPTH x ADDR_WIDTH register array plus sp of $clog2(DEPTH) bits; pc = entry[sp].
- All ops are registered. Results are visible on pc/level the cycle after the sampling edge.
- NOP: no change.
- INC: entry[sp] <= pc+1, modulo 2^ADDR_WIDTH (0x3FFF -> 0x0000 at width 14). level unchanged.
- JUMP: entry[sp] <= addr_in. level unchanged.
- CALL when level < DEPTH-1:
  - sp <= sp+1 (mod DEPTH), entry[sp+1] <= addr_in, level <= level+1;
  - the old entry keeps the current pc unmodified (the core has already advanced pc past the instruction).
- RSTV: identical to CALL with target {zeros, vec_in, 3'b000}, e.g. vec 5 -> 0x0028.
- RET when level > 0: sp <= sp-1 (mod DEPTH), level <= level-1. The popped entry is left stale, not cleared.
- CALL/RSTV at level == DEPTH-1:
  - overflow pulses in both modes;
  - WRAP_MODE=1: sp advances mod DEPTH, the oldest saved entry is overwritten with the target, level stays DEPTH-1;
  - WRAP_MODE=0: op ignored (sp, pc, entries unchanged), fault <= 1.
- RET at level == 0:
  - underflow pulses in both modes;
  - WRAP_MODE=1: sp retreats mod DEPTH, pc shows the stale entry, level stays 0;
  - WRAP_MODE=0: op ignored, fault <= 1.
- fault:
  - tied 0 when WRAP_MODE=1;
  - otherwise cleared by reset or by clr_fault;
  - if clr_fault and a faulting op occur in the same cycle, set wins (fault = 1).
- overflow/underflow are high for exactly one cycle per offending op; back-to-back offending ops give continuous high.
- Undefined op codes 110/111 behave as NOP and never flag.

Test Plan:
1. Reset, then INC x3 -> pc 0,1,2,3 on successive cycles; level 0; no flags.
2. JUMP 0x3FFF then INC -> pc 0x3FFF then 0x0000; level 0.
3. JUMP 0x0100; CALL 0x0200 -> pc 0x0200, level 1; INC -> 0x0201; RET -> pc 0x0100, level 0. RSTV vec 5 -> pc 0x0028, level 1.
4. WRAP_MODE=1, DEPTH=8, from pc 0: CALL 1..7 -> level 7.
   - CALL 8 -> pc 8, overflow pulse, level 7.
   - 7 RETs -> pc 7,6,...,1, level 0.
   - 8th RET -> pc 8 (stale entry), underflow pulse, level 0.
5. WRAP_MODE=0: CALL 1..7 -> level 7.
   - CALL 8 -> pc stays 7, overflow pulse, fault=1.
   - 7 RETs -> pc 0, level 0.
   - Extra RET -> pc 0, underflow pulse, fault still 1.
   - clr_fault -> fault 0. clr_fault with simultaneous RET at level 0 -> fault 1.
6. At level 3, pc 0x0123, assert rst between clock edges -> pc 0, level 0, flags 0 before the next edge. Deassert, INC -> pc 1.

Source files
------------

// File: rtl/i8008_addr_stack.sv
// i8008_addr_stack
//   Program-counter / return-address stack for the i8008 core family.
//   The entry addressed by the stack pointer is the live PC. One op per
//   cycle: INC, JUMP, CALL, RET, RSTV (NOP and undefined codes do nothing).
//   WRAP_MODE=1 reproduces the circular 8008 behaviour (overwrite oldest on
//   overflow, stale pop on underflow); WRAP_MODE=0 ignores illegal ops and
//   raises a sticky fault.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   op         000 NOP, 001 INC, 010 JUMP, 011 CALL, 100 RET, 101 RSTV
//   addr_in    JUMP/CALL target
//   vec_in     RST vector number (target = vec_in * 8)
//   clr_fault  synchronous fault clear (a simultaneous fault set wins)
//   pc         live PC (top-of-stack entry)
//   level      number of saved return addresses, 0..DEPTH-1
//   overflow   one-cycle pulse: CALL/RSTV with level == DEPTH-1
//   underflow  one-cycle pulse: RET with level == 0
//   fault      sticky error flag (always 0 when WRAP_MODE=1)
module i8008_addr_stack #(
    parameter int ADDR_WIDTH = 14,
    parameter int DEPTH      = 8,
    parameter int WRAP_MODE  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               op,
    input  logic [ADDR_WIDTH-1:0]    addr_in,
    input  logic [2:0]               vec_in,
    input  logic                     clr_fault,
    output logic [ADDR_WIDTH-1:0]    pc,
    output logic [$clog2(DEPTH)-1:0] level,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     fault
);

    localparam int LW = $clog2(DEPTH);
    localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH - 1);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_INC  = 3'b001,
        OP_JUMP = 3'b010,
        OP_CALL = 3'b011,
        OP_RET  = 3'b100,
        OP_RSTV = 3'b101
    } op_e;

    logic [ADDR_WIDTH-1:0] stack_q [DEPTH];
    logic [LW-1:0]         sp_q, sp_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  fault_q, fault_d;

    logic                  wr_en;
    logic [LW-1:0]         wr_idx;
    logic [ADDR_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] target;
    logic                  fault_set;
    logic                  full;
    logic                  empty;
    op_e                   op_dec;

    assign op_dec = op_e'(op);
    assign full   = (level_q == LVL_MAX);
    assign empty  = (level_q == '0);

    always_comb begin
        target = addr_in;
        if (op_dec == OP_RSTV) begin
            target      = '0;
            target[5:0] = {vec_in, 3'b000};
        end
    end

    always_comb begin
        sp_d        = sp_q;
        level_d     = level_q;
        wr_en       = 1'b0;
        wr_idx      = sp_q;
        wr_data     = pc;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        fault_set   = 1'b0;

        case (op_dec)
            OP_INC: begin
                wr_en   = 1'b1;
                wr_data = pc + ADDR_WIDTH'(1);
            end
            OP_JUMP: begin
                wr_en   = 1'b1;
                wr_data = addr_in;
            end
            OP_CALL, OP_RSTV: begin
                overflow_d = full;
                // In wrap mode a full push still advances and lands on the
                // oldest saved entry; level is pinned at DEPTH-1.
                if (!full || (WRAP_MODE != 0)) begin
                    sp_d    = sp_q + LW'(1);
                    wr_en   = 1'b1;
                    wr_idx  = sp_q + LW'(1);
                    wr_data = target;
                    if (!full) begin
                        level_d = level_q + LW'(1);
                    end
                end else begin
                    fault_set = 1'b1;
                end
            end
            OP_RET: begin
                underflow_d = empty;
                // Popped entries are never cleared, so a wrap-mode underflow
                // exposes whatever stale address sits below.
                if (!empty || (WRAP_MODE != 0)) begin
                    sp_d = sp_q - LW'(1);
                    if (!empty) begin
                        level_d = level_q - LW'(1);
                    end
                end else begin
                    fault_set = 1'b1;
                end
            end
            default: ;
        endcase

        if (WRAP_MODE != 0) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_set | (fault_q & ~clr_fault);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
            sp_q        <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            if (wr_en) begin
                stack_q[wr_idx] <= wr_data;
            end
            sp_q        <= sp_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            fault_q     <= fault_d;
        end
    end

    assign pc        = stack_q[sp_q];
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_i8008_addr_stack.sv
// Scoreboard bench: two instances (wrap and saturating) share stimulus.
// The driver steps two reference models and queues the expected outputs;
// the monitor pops one expectation per committed op and compares.
module tb_i8008_addr_stack;

    localparam int AW    = 14;
    localparam int D     = 8;
    localparam int LW    = 3;
    localparam int AMASK = (1 << AW) - 1;

    localparam logic [2:0] NOP = 3'd0, INC = 3'd1, JMP = 3'd2,
                           CAL = 3'd3, RET = 3'd4, RSV = 3'd5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    op = NOP;
    logic [AW-1:0] addr_in = '0;
    logic [2:0]    vec_in = '0;
    logic          clr_fault = 1'b0;

    logic [AW-1:0] w_pc, s_pc;
    logic [LW-1:0] w_lvl, s_lvl;
    logic          w_ovf, w_unf, w_flt, s_ovf, s_unf, s_flt;

    i8008_addr_stack #(.ADDR_WIDTH(AW), .DEPTH(D), .WRAP_MODE(1)) u_wrap (
        .clk(clk), .rst(rst), .op(op), .addr_in(addr_in), .vec_in(vec_in),
        .clr_fault(clr_fault), .pc(w_pc), .level(w_lvl),
        .overflow(w_ovf), .underflow(w_unf), .fault(w_flt)
    );

    i8008_addr_stack #(.ADDR_WIDTH(AW), .DEPTH(D), .WRAP_MODE(0)) u_sat (
        .clk(clk), .rst(rst), .op(op), .addr_in(addr_in), .vec_in(vec_in),
        .clr_fault(clr_fault), .pc(s_pc), .level(s_lvl),
        .overflow(s_ovf), .underflow(s_unf), .fault(s_flt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int wpc, wlvl, wovf, wunf;
        int spc, slvl, sovf, sunf, sflt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Wrap model: circular memory, pointer, saturating level count.
    int wmem[D];
    int wsp, wlvl;
    // Saturating model: live pc plus a bounded list of saved returns.
    int spc;
    int ssaved[$];
    int sflt;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) wmem[i] = 0;
        wsp = 0; wlvl = 0;
        spc = 0; ssaved.delete(); sflt = 0;
    endtask

    task automatic model_step(input logic [2:0] o, input int a, input int v,
                              input logic c, output exp_t e);
        int t;
        int wo, wu, so, su, sset;
        wo = 0; wu = 0; so = 0; su = 0; sset = 0;
        t = (o == RSV) ? v * 8 : a;
        case (o)
            INC: begin
                wmem[wsp] = (wmem[wsp] + 1) & AMASK;
                spc = (spc + 1) & AMASK;
            end
            JMP: begin
                wmem[wsp] = a;
                spc = a;
            end
            CAL, RSV: begin
                wo = (wlvl == D - 1);
                wsp = (wsp + 1) % D;
                wmem[wsp] = t;
                if (!wo) wlvl++;
                if (ssaved.size() == D - 1) begin
                    so = 1; sset = 1;
                end else begin
                    ssaved.push_back(spc);
                    spc = t;
                end
            end
            RET: begin
                wu = (wlvl == 0);
                wsp = (wsp + D - 1) % D;
                if (!wu) wlvl--;
                if (ssaved.size() == 0) begin
                    su = 1; sset = 1;
                end else begin
                    spc = ssaved.pop_back();
                end
            end
            default: ;
        endcase
        if (sset) sflt = 1;
        else if (c) sflt = 0;
        e.wpc = wmem[wsp]; e.wlvl = wlvl; e.wovf = wo; e.wunf = wu;
        e.spc = spc; e.slvl = ssaved.size(); e.sovf = so; e.sunf = su; e.sflt = sflt;
    endtask

    task automatic drive(input logic [2:0] o, input int a, input int v, input logic c);
        exp_t e;
        @(negedge clk);
        op = o; addr_in = AW'(a); vec_in = 3'(v); clr_fault = c;
        model_step(o, a, v, c, e);
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_w_pc"}, int'(w_pc), 0);
        chk({tag, "_w_lvl"}, int'(w_lvl), 0);
        chk({tag, "_w_flags"}, int'({w_ovf, w_unf, w_flt}), 0);
        chk({tag, "_s_pc"}, int'(s_pc), 0);
        chk({tag, "_s_lvl"}, int'(s_lvl), 0);
        chk({tag, "_s_flags"}, int'({s_ovf, s_unf, s_flt}), 0);
    endtask

    // Async reset asserted between edges; outputs must clear before the next edge.
    task automatic mid_reset();
        drive(NOP, 0, 0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: each committed op presents a result one edge later.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("w_pc", int'(w_pc), e.wpc);
            chk("w_level", int'(w_lvl), e.wlvl);
            chk("w_overflow", int'(w_ovf), e.wovf);
            chk("w_underflow", int'(w_unf), e.wunf);
            chk("w_fault", int'(w_flt), 0);
            chk("s_pc", int'(s_pc), e.spc);
            chk("s_level", int'(s_lvl), e.slvl);
            chk("s_overflow", int'(s_ovf), e.sovf);
            chk("s_underflow", int'(s_unf), e.sunf);
            chk("s_fault", int'(s_flt), e.sflt);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        logic [2:0] ro;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // INC sequence and address wrap
        repeat (3) drive(INC, 0, 0, 1'b0);
        drive(JMP, 'h3FFF, 0, 1'b0);
        drive(INC, 0, 0, 1'b0);

        // call/return and RST vector
        drive(JMP, 'h0100, 0, 1'b0);
        drive(CAL, 'h0200, 0, 1'b0);
        drive(INC, 0, 0, 1'b0);
        drive(RET, 0, 0, 1'b0);
        drive(RSV, 0, 5, 1'b0);

        // fill, overflow, drain, underflow, fault clear/set priority
        mid_reset();
        for (int i = 1; i <= 8; i++) drive(CAL, i, 0, 1'b0);
        repeat (8) drive(RET, 0, 0, 1'b0);
        drive(RET, 0, 0, 1'b0);
        drive(NOP, 0, 0, 1'b1);
        drive(RET, 0, 0, 1'b1);
        drive(RSV, 0, 7, 1'b0);

        // reset mid-operation at level 3, then resume
        mid_reset();
        drive(CAL, 'h0011, 0, 1'b0);
        drive(CAL, 'h0022, 0, 1'b0);
        drive(CAL, 'h0123, 0, 1'b0);
        mid_reset();
        drive(INC, 0, 0, 1'b0);

        // undefined op codes
        drive(3'd6, 'h1234, 2, 1'b0);
        drive(3'd7, 'h0555, 3, 1'b0);

        // random traffic: push-biased then pop-biased
        for (int phase = 0; phase < 2; phase++) begin
            for (int n = 0; n < 300; n++) begin
                ro = 3'($urandom_range(0, 7));
                if (phase == 0 && $urandom_range(0, 2) == 0) ro = CAL;
                if (phase == 1 && $urandom_range(0, 1) == 0) ro = RET;
                drive(ro, int'($urandom_range(0, AMASK)), int'($urandom_range(0, 7)),
                      ($urandom_range(0, 15) == 0));
            end
        end

        drive(NOP, 0, 0, 1'b0);
        @(posedge clk);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
